// File: rtl/mips_defs.sv
// Shared MIPS decode definitions for the pipeline hazard logic: field positions,
// opcode/funct encodings, the 2-bit pipeline-time type and instruction class helpers.
package mips_defs;

   localparam int OP_HI = 31;
   localparam int OP_LO = 26;
   localparam int RS_HI = 25;
   localparam int RS_LO = 21;
   localparam int RT_HI = 20;
   localparam int RT_LO = 16;
   localparam int RD_HI = 15;
   localparam int RD_LO = 11;
   localparam int FN_HI = 5;
   localparam int FN_LO = 0;

   typedef logic [1:0] t_time;
   localparam t_time T0 = 2'd0;
   localparam t_time T1 = 2'd1;
   localparam t_time T2 = 2'd2;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;

   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_SLLV  = 6'h04;
   localparam logic [5:0] F_SRLV  = 6'h06;
   localparam logic [5:0] F_SRAV  = 6'h07;
   localparam logic [5:0] F_JR    = 6'h08;
   localparam logic [5:0] F_JALR  = 6'h09;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_SLTU  = 6'h2B;

   typedef struct packed {
      logic  rs_used;
      t_time rs_tuse;
      logic  rt_used;
      t_time rt_tuse;
   } t_src;

   function automatic logic f_is_shift_imm(input logic [5:0] fn);
      return (fn == F_SLL) || (fn == F_SRL) || (fn == F_SRA);
   endfunction

   function automatic logic f_is_alu_r(input logic [5:0] op, input logic [5:0] fn);
      return (op == OP_SPECIAL) &&
             (f_is_shift_imm(fn) || (fn == F_SLLV) || (fn == F_SRLV) || (fn == F_SRAV) ||
              ((fn >= F_ADD) && (fn <= F_NOR)) || (fn == F_SLT) || (fn == F_SLTU));
   endfunction

   function automatic logic f_is_mul(input logic [5:0] op, input logic [5:0] fn);
      return (op == OP_SPECIAL) && ((fn == F_MULT) || (fn == F_MULTU));
   endfunction

   function automatic logic f_is_div(input logic [5:0] op, input logic [5:0] fn);
      return (op == OP_SPECIAL) && ((fn == F_DIV) || (fn == F_DIVU));
   endfunction

   function automatic logic f_is_mf(input logic [5:0] op, input logic [5:0] fn);
      return (op == OP_SPECIAL) && ((fn == F_MFHI) || (fn == F_MFLO));
   endfunction

   function automatic logic f_is_mt(input logic [5:0] op, input logic [5:0] fn);
      return (op == OP_SPECIAL) && ((fn == F_MTHI) || (fn == F_MTLO));
   endfunction

   function automatic logic f_is_md_any(input logic [5:0] op, input logic [5:0] fn);
      return f_is_mul(op, fn) || f_is_div(op, fn) || f_is_mf(op, fn) || f_is_mt(op, fn);
   endfunction

   function automatic logic f_is_load(input logic [5:0] op);
      return (op >= OP_LB) && (op <= OP_LHU);
   endfunction

   function automatic logic f_is_alu_i(input logic [5:0] op);
      return (op >= OP_ADDI) && (op <= OP_XORI);
   endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide occupancy counter: reloads when an MD op sits in E, otherwise
// counts down to zero; busy covers both the op in E and the remaining count.
module md_busy_cnt #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mul_e_i,
   input  logic div_e_i,
   output logic md_busy_o
);

   logic [4:0] md_cnt_q, md_cnt_d;

   always_comb begin
      md_cnt_d = md_cnt_q;
      if (mul_e_i) begin
         md_cnt_d = 5'(MUL_CYCLES);
      end else if (div_e_i) begin
         md_cnt_d = 5'(DIV_CYCLES);
      end else if (md_cnt_q != 5'd0) begin
         md_cnt_d = md_cnt_q - 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_cnt_q <= 5'd0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

   assign md_busy_o = (md_cnt_q != 5'd0) | mul_e_i | div_e_i;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall controller: Tuse/Tnew data-hazard detection between D and E/M,
// HI/LO access interlock against the MD unit, and a saturating stall-cycle counter.
module hazard_ctrl
   import mips_defs::*;
#(
   parameter int MUL_CYCLES  = 5,
   parameter int DIV_CYCLES  = 10,
   parameter bit BRANCH_IN_D = 1'b1,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      IR_D,
   input  logic [31:0]      IR_E,
   input  logic [31:0]      IR_M,
   output logic             PC_en,
   output logic             IR_D_en,
   output logic             IR_E_clr,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam t_time TUSE_BR = BRANCH_IN_D ? T0 : T1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic t_src f_src(input logic [5:0] op, input logic [5:0] fn);
      t_src s;
      s = '0;
      if (op == OP_SPECIAL) begin
         if ((fn == F_JR) || (fn == F_JALR)) begin
            s.rs_used = 1'b1;
            s.rs_tuse = TUSE_BR;
         end else if (f_is_shift_imm(fn)) begin
            s.rt_used = 1'b1;
            s.rt_tuse = T1;
         end else if (f_is_alu_r(op, fn) || f_is_mul(op, fn) || f_is_div(op, fn)) begin
            s.rs_used = 1'b1;
            s.rs_tuse = T1;
            s.rt_used = 1'b1;
            s.rt_tuse = T1;
         end else if (f_is_mt(op, fn)) begin
            s.rs_used = 1'b1;
            s.rs_tuse = T1;
         end
      end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
         s.rs_used = 1'b1;
         s.rs_tuse = TUSE_BR;
         s.rt_used = 1'b1;
         s.rt_tuse = TUSE_BR;
      end else if ((op == OP_BLEZ) || (op == OP_BGTZ) || (op == OP_REGIMM)) begin
         s.rs_used = 1'b1;
         s.rs_tuse = TUSE_BR;
      end else if (f_is_alu_i(op) || f_is_load(op)) begin
         s.rs_used = 1'b1;
         s.rs_tuse = T1;
      end else if (op >= OP_SB) begin
         s.rs_used = 1'b1;
         s.rs_tuse = T1;
         s.rt_used = 1'b1;
         s.rt_tuse = T2;
      end
      return s;
   endfunction

   // $0 as a destination is returned as 0 and never matches in f_hit.
   function automatic logic [4:0] f_dst(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [4:0] rt, input logic [4:0] rd);
      logic [4:0] d;
      d = 5'd0;
      if (f_is_alu_r(op, fn) || f_is_mf(op, fn) || ((op == OP_SPECIAL) && (fn == F_JALR))) begin
         d = rd;
      end else if (f_is_alu_i(op) || (op == OP_LUI) || f_is_load(op)) begin
         d = rt;
      end else if (op == OP_JAL) begin
         d = 5'd31;
      end
      return d;
   endfunction

   function automatic t_time f_tnew_e(input logic [5:0] op, input logic [5:0] fn);
      t_time t;
      t = T0;
      if (f_is_load(op)) begin
         t = T2;
      end else if (f_is_alu_r(op, fn) || f_is_alu_i(op) || (op == OP_LUI) || f_is_mf(op, fn)) begin
         t = T1;
      end
      return t;
   endfunction

   function automatic logic f_hit(input logic used, input logic [4:0] src, input t_time tuse,
                                  input logic [4:0] dst, input t_time tnew);
      return used && (dst != 5'd0) && (src == dst) && (tuse < tnew);
   endfunction

   logic [5:0] op_d, fn_d, op_e, fn_e, op_m, fn_m;
   logic [4:0] rs_d, rt_d, dst_e, dst_m;
   t_src       src_d;
   t_time      tnew_e, tnew_m;
   logic       stall_data, stall_md, stall;
   logic       mul_e, div_e;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic       unused_fields;

   assign op_d = IR_D[OP_HI:OP_LO];
   assign fn_d = IR_D[FN_HI:FN_LO];
   assign rs_d = IR_D[RS_HI:RS_LO];
   assign rt_d = IR_D[RT_HI:RT_LO];
   assign op_e = IR_E[OP_HI:OP_LO];
   assign fn_e = IR_E[FN_HI:FN_LO];
   assign op_m = IR_M[OP_HI:OP_LO];
   assign fn_m = IR_M[FN_HI:FN_LO];

   assign unused_fields = ^{IR_D[15:6], IR_E[25:21], IR_E[10:6], IR_M[25:21], IR_M[10:6]};

   assign src_d  = f_src(op_d, fn_d);
   assign dst_e  = f_dst(op_e, fn_e, IR_E[RT_HI:RT_LO], IR_E[RD_HI:RD_LO]);
   assign dst_m  = f_dst(op_m, fn_m, IR_M[RT_HI:RT_LO], IR_M[RD_HI:RD_LO]);
   assign tnew_e = f_tnew_e(op_e, fn_e);
   assign tnew_m = f_is_load(op_m) ? T1 : T0;

   assign stall_data = f_hit(src_d.rs_used, rs_d, src_d.rs_tuse, dst_e, tnew_e) |
                       f_hit(src_d.rt_used, rt_d, src_d.rt_tuse, dst_e, tnew_e) |
                       f_hit(src_d.rs_used, rs_d, src_d.rs_tuse, dst_m, tnew_m) |
                       f_hit(src_d.rt_used, rt_d, src_d.rt_tuse, dst_m, tnew_m);

   assign mul_e = f_is_mul(op_e, fn_e);
   assign div_e = f_is_div(op_e, fn_e);

   md_busy_cnt #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md_busy_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .mul_e_i   (mul_e),
      .div_e_i   (div_e),
      .md_busy_o (md_busy)
   );

   assign stall_md = f_is_md_any(op_d, fn_d) & md_busy;
   assign stall    = stall_data | stall_md;

   assign PC_en    = ~stall;
   assign IR_D_en  = ~stall;
   assign IR_E_clr = stall;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances (default, compare-in-E branches,
// 3-bit stall counter) driven by shared IRs and checked every cycle on the falling edge.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] IR_D, IR_E, IR_M;

   logic        pc_en_a, ird_en_a, ire_clr_a, busy_a;
   logic [31:0] cnt_a;
   logic        pc_en_b, ird_en_b, ire_clr_b, busy_b;
   logic [31:0] cnt_b;
   logic        pc_en_c, ird_en_c, ire_clr_c, busy_c;
   logic [2:0]  cnt_c;

   always #5 clk = ~clk;

   hazard_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M),
      .PC_en(pc_en_a), .IR_D_en(ird_en_a), .IR_E_clr(ire_clr_a), .md_busy(busy_a),
      .stall_cnt(cnt_a)
   );

   hazard_ctrl #(.BRANCH_IN_D(1'b0)) u_dut_b0 (
      .clk(clk), .rst_n(rst_n), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M),
      .PC_en(pc_en_b), .IR_D_en(ird_en_b), .IR_E_clr(ire_clr_b), .md_busy(busy_b),
      .stall_cnt(cnt_b)
   );

   hazard_ctrl #(.CNT_W(3)) u_dut_c3 (
      .clk(clk), .rst_n(rst_n), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M),
      .PC_en(pc_en_c), .IR_D_en(ird_en_c), .IR_E_clr(ire_clr_c), .md_busy(busy_c),
      .stall_cnt(cnt_c)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      string       tag;
      logic        st_a;
      logic        st_b;
      logic        busy;
      logic [31:0] cnt_a;
      logic [31:0] cnt_b;
      logic [2:0]  cnt_c;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_cnt_a, m_cnt_b;
   logic [2:0]  m_cnt_c;

   always @(negedge clk) begin
      exp_t x;
      if (sb.size() != 0) begin
         x = sb.pop_front();
         chk({x.tag, ".pc_en"},    32'(pc_en_a),   32'(!x.st_a));
         chk({x.tag, ".ird_en"},   32'(ird_en_a),  32'(!x.st_a));
         chk({x.tag, ".ire_clr"},  32'(ire_clr_a), 32'(x.st_a));
         chk({x.tag, ".b0_clr"},   32'(ire_clr_b), 32'(x.st_b));
         chk({x.tag, ".b0_pc_en"}, 32'(pc_en_b),   32'(!x.st_b));
         chk({x.tag, ".c3_clr"},   32'(ire_clr_c), 32'(x.st_a));
         chk({x.tag, ".busy"},     32'(busy_a),    32'(x.busy));
         chk({x.tag, ".cnt"},      cnt_a,          x.cnt_a);
         chk({x.tag, ".b0_cnt"},   cnt_b,          x.cnt_b);
         chk({x.tag, ".c3_cnt"},   32'(cnt_c),     32'(x.cnt_c));
      end
   end

   // Drive one cycle of IRs (just after the rising edge) and queue what must be seen.
   task automatic step(input string tag, input logic [31:0] d, input logic [31:0] e,
                       input logic [31:0] m, input logic st_a, input logic st_b,
                       input logic busy);
      exp_t x;
      IR_D = d;
      IR_E = e;
      IR_M = m;
      x.tag   = tag;
      x.st_a  = st_a;
      x.st_b  = st_b;
      x.busy  = busy;
      x.cnt_a = m_cnt_a;
      x.cnt_b = m_cnt_b;
      x.cnt_c = m_cnt_c;
      sb.push_back(x);
      if (st_a) m_cnt_a = m_cnt_a + 1;
      if (st_b) m_cnt_b = m_cnt_b + 1;
      if (st_a && (m_cnt_c != 3'd7)) m_cnt_c = m_cnt_c + 3'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      IR_D = '0;
      IR_E = '0;
      IR_M = '0;
      #2;
      chk("rst.cnt", cnt_a, 32'd0);
      chk("rst.busy", 32'(busy_a), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      m_cnt_a = '0;
      m_cnt_b = '0;
      m_cnt_c = '0;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   logic [31:0] lw8, lw9, lw4, addu10, beq40, addiu4, nop;
   logic [31:0] div45, mult89, mflo2, mfhi2, mthi8;

   initial begin
      nop    = '0;
      lw8    = i_op(6'h23, 9, 8, 0);
      lw9    = i_op(6'h23, 1, 9, 4);
      lw4    = i_op(6'h23, 1, 4, 0);
      addu10 = r_op(8, 11, 10, 6'h21);
      beq40  = i_op(6'h04, 4, 0, 3);
      addiu4 = i_op(6'h09, 4, 4, 1);
      div45  = r_op(4, 5, 0, 6'h1A);
      mult89 = r_op(8, 9, 0, 6'h18);
      mflo2  = r_op(0, 0, 2, 6'h12);
      mfhi2  = r_op(0, 0, 2, 6'h10);
      mthi8  = r_op(8, 0, 0, 6'h11);
      m_cnt_a = '0;
      m_cnt_b = '0;
      m_cnt_c = '0;

      // Reset held with random IRs; counters must stay cleared.
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         IR_D = $urandom;
         IR_E = $urandom;
         IR_M = $urandom;
         @(posedge clk);
         #1;
      end
      chk("rst_rand.cnt", cnt_a, 32'd0);
      chk("rst_rand.c3_cnt", 32'(cnt_c), 32'd0);
      @(negedge clk);
      IR_D = '0;
      IR_E = '0;
      IR_M = '0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step("reset_nop", nop, nop, nop, 1'b0, 1'b0, 1'b0);

      // Continuous load-use stall saturates the 3-bit counter.
      for (int i = 0; i < 10; i++) step("sat", addu10, lw8, nop, 1'b1, 1'b1, 1'b0);
      step("sat_end", nop, nop, nop, 1'b0, 1'b0, 1'b0);
      chk("sat.c3_cnt_7", 32'(cnt_c), 32'd7);
      chk("sat.cnt_10", cnt_a, 32'd10);

      do_reset();
      step("lu_e", addu10, lw8, nop, 1'b1, 1'b1, 1'b0);
      step("lu_m", addu10, nop, lw8, 1'b0, 1'b0, 1'b0);
      step("lu_done", nop, nop, nop, 1'b0, 1'b0, 1'b0);
      chk("lu.cnt_1", cnt_a, 32'd1);

      step("br_alu", beq40, addiu4, nop, 1'b1, 1'b0, 1'b0);
      step("zero_dst", r_op(0, 0, 2, 6'h21), i_op(6'h23, 1, 0, 0), nop, 1'b0, 1'b0, 1'b0);
      step("overlap", i_op(6'h04, 5, 4, 1), r_op(1, 2, 5, 6'h21), lw4, 1'b1, 1'b0, 1'b0);
      step("br_ld_m", beq40, nop, lw4, 1'b1, 1'b0, 1'b0);
      step("alu_ld_m", r_op(4, 3, 7, 6'h21), nop, lw4, 1'b0, 1'b0, 1'b0);
      step("sw_rt_e", i_op(6'h2B, 9, 8, 0), lw8, nop, 1'b0, 1'b0, 1'b0);
      step("sw_rs_e", i_op(6'h2B, 9, 8, 0), lw9, nop, 1'b1, 1'b1, 1'b0);
      step("jr_jal", r_op(31, 0, 0, 6'h08), {6'h03, 26'h10}, nop, 1'b0, 1'b0, 1'b0);
      step("jr_alu", r_op(31, 0, 0, 6'h08), r_op(1, 2, 31, 6'h21), nop, 1'b1, 1'b0, 1'b0);
      step("lui_alu", i_op(6'h09, 7, 3, 2), i_op(6'h0F, 0, 7, 5), nop, 1'b0, 1'b0, 1'b0);
      step("lui_br", i_op(6'h05, 7, 0, 2), i_op(6'h0F, 0, 7, 5), nop, 1'b1, 1'b0, 1'b0);
      step("sll_ld", r_op(0, 6, 3, 6'h00), i_op(6'h23, 1, 6, 0), nop, 1'b1, 1'b1, 1'b0);

      // mflo behind div: stalled cycles 0..10, free at 11.
      step("div_c0", mflo2, div45, nop, 1'b1, 1'b1, 1'b1);
      for (int i = 1; i <= 10; i++) step("div_wait", mflo2, nop, nop, 1'b1, 1'b1, 1'b1);
      step("div_c11", mflo2, nop, nop, 1'b0, 1'b0, 1'b0);

      // mfhi behind mult: MUL_CYCLES+1 stalls.
      step("mul_c0", mfhi2, mult89, nop, 1'b1, 1'b1, 1'b1);
      for (int i = 1; i <= 5; i++) step("mul_wait", mfhi2, nop, nop, 1'b1, 1'b1, 1'b1);
      step("mul_c6", mfhi2, nop, nop, 1'b0, 1'b0, 1'b0);

      // Data and MD stall together count once per cycle.
      step("both_c0", nop, mult89, nop, 1'b0, 1'b0, 1'b1);
      step("both_c1", mthi8, lw8, nop, 1'b1, 1'b1, 1'b1);
      for (int i = 2; i <= 5; i++) step("both_md", mthi8, nop, nop, 1'b1, 1'b1, 1'b1);
      step("both_c6", mthi8, nop, nop, 1'b0, 1'b0, 1'b0);

      // div reaching E while the mult count runs: the reload wins.
      step("coll_mul", nop, mult89, nop, 1'b0, 1'b0, 1'b1);
      step("coll_div", nop, div45, nop, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step("coll_wait", nop, nop, nop, 1'b0, 1'b0, 1'b1);
      step("coll_idle", nop, nop, nop, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a divide drops md_busy at once.
      step("rdiv_c0", nop, div45, nop, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step("rdiv_wait", nop, nop, nop, 1'b0, 1'b0, 1'b1);
      chk("rdiv.busy_pre", 32'(busy_a), 32'd1);
      do_reset();
      step("rdiv_after", mflo2, nop, nop, 1'b0, 1'b0, 1'b0);
      step("end_nop", nop, nop, nop, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
